pattern_scan_ctrl: RTL and testbench

PATTERN_SCAN_CTRL -- requirements
Module: pattern_scan_ctrl

---
 rtl/pattern_scan_ctrl_pkg.sv | 14 +
 rtl/pattern_window.sv | 30 +++
 rtl/pattern_scan_ctrl.sv | 95 +++++++++
 tb/tb_pattern_scan_ctrl.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/pattern_scan_ctrl_pkg.sv
// Shared types and constants for the serial pattern-scan controller.
package pattern_scan_ctrl_pkg;

   localparam int DEF_WORD_W = 16;
   localparam int DEF_CNT_W  = 5;
   localparam int PAT_W      = 4;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SHIFT  = 2'd1,
      REPORT = 2'd2
   } state_t;

endpackage : pattern_scan_ctrl_pkg

// File: rtl/pattern_window.sv
// Sliding history of the last bits fed plus a Mealy compare against the pattern.
module pattern_window
   import pattern_scan_ctrl_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   input  logic             clr,
   input  logic             en,
   input  logic             bit_in,
   input  logic [PAT_W-1:0] pattern,
   output logic             match
);

   // Only PAT_W-1 bits of history are stored; the current bit completes the window.
   logic [PAT_W-2:0] r_win;

   // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_win <= '0;
      end else if (clr) begin
         r_win <= '0;
      end else if (en) begin
         r_win <= {r_win[PAT_W-3:0], bit_in};
      end
   end

   assign match = ({r_win, bit_in} == pattern);

endmodule : pattern_window

// File: rtl/pattern_scan_ctrl.sv
// Accepts a word, shifts it MSB first through a pattern detector, reports the match count.
module pattern_scan_ctrl
   import pattern_scan_ctrl_pkg::*;
#(
   parameter int WORD_W = DEF_WORD_W,
   parameter int CNT_W  = DEF_CNT_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [WORD_W-1:0] in_data,
   input  logic [PAT_W-1:0]  pattern,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [CNT_W-1:0]  out_count,
   output logic              ser_bit,
   output logic              ser_match
);

   localparam int IDX_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;

   state_t            r_state;
   state_t            w_state_nxt;
   logic [WORD_W-1:0] r_shift;
   logic [PAT_W-1:0]  r_pat;
   logic [IDX_W-1:0]  r_idx;
   logic [CNT_W-1:0]  r_count;

   logic w_accept;
   logic w_shifting;
   logic w_last;
   logic w_win_match;

   assign w_accept   = in_valid && (r_state == IDLE);
   assign w_shifting = (r_state == SHIFT);
   assign w_last     = (r_idx == IDX_W'(WORD_W - 1));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // NOTE: the next state gets a default first so no path through the case infers a latch.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (in_valid)  w_state_nxt = SHIFT;
         SHIFT:   if (w_last)    w_state_nxt = REPORT;
         REPORT:  if (out_ready) w_state_nxt = IDLE;
         default:                w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_shift <= '0;
         r_pat   <= '0;
         r_idx   <= '0;
         r_count <= '0;
      end else if (w_accept) begin
         r_shift <= in_data;
         r_pat   <= pattern;
         r_idx   <= '0;
         r_count <= '0;
      end else if (w_shifting) begin
         r_shift <= r_shift << 1;
         r_idx   <= r_idx + IDX_W'(1);
         // Count cannot exceed WORD_W-3, so no saturation is needed.
         if (ser_match) r_count <= r_count + CNT_W'(1);
      end
   end

   pattern_window u_window (
      .clk     (clk),
      .reset   (reset),
      .clr     (w_accept),
      .en      (w_shifting),
      .bit_in  (ser_bit),
      .pattern (r_pat),
      .match   (w_win_match)
   );

   // A match needs a full window of bits from the current word.
   assign ser_bit   = w_shifting && r_shift[WORD_W-1];
   assign ser_match = w_shifting && (r_idx >= IDX_W'(PAT_W - 1)) && w_win_match;

   assign in_ready  = (r_state == IDLE);
   assign out_valid = (r_state == REPORT);
   assign out_count = r_count;

endmodule : pattern_scan_ctrl

// File: tb/tb_pattern_scan_ctrl.sv
// Directed, table-driven bench for pattern_scan_ctrl with WORD_W=16, CNT_W=5.
module tb_pattern_scan_ctrl;

   localparam int WORD_W = 16;
   localparam int CNT_W  = 5;
   localparam int NVEC   = 8;

   typedef struct {
      logic [WORD_W-1:0] data;
      logic [3:0]        pat;
      int                cnt;
      logic [WORD_W-1:0] mask;   // bit i set = ser_match expected at bit index i
   } vec_t;

   logic              clk;
   logic              reset;
   logic              in_valid;
   logic              in_ready;
   logic [WORD_W-1:0] in_data;
   logic [3:0]        pattern;
   logic              out_valid;
   logic              out_ready;
   logic [CNT_W-1:0]  out_count;
   logic              ser_bit;
   logic              ser_match;

   int   checks = 0;
   int   errors = 0;
   int   cyc    = 0;
   vec_t tab [NVEC];

   pattern_scan_ctrl #(.WORD_W(WORD_W), .CNT_W(CNT_W)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .pattern   (pattern),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_count (out_count),
      .ser_bit   (ser_bit),
      .ser_match (ser_match)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Called at a negedge in IDLE; returns at the negedge of the first IDLE cycle afterwards.
   task automatic run_scan(input vec_t v, input int hold);
      check("idle_in_ready", 32'(in_ready), 32'd1);
      in_valid  = 1'b1;
      in_data   = v.data;
      pattern   = v.pat;
      out_ready = 1'b0;
      @(negedge clk);
      // Scrambled inputs and a spurious in_valid must not disturb the scan.
      in_data = ~v.data;
      pattern = ~v.pat;
      for (int i = 0; i < WORD_W; i++) begin
         check($sformatf("ser_bit[%0d]", i), 32'(ser_bit), 32'(v.data[WORD_W-1-i]));
         check($sformatf("ser_match[%0d]", i), 32'(ser_match), 32'(v.mask[i]));
         check("shift_flags", {30'd0, in_ready, out_valid}, 32'd0);
         @(negedge clk);
      end
      for (int h = 0; h <= hold; h++) begin
         check("report_valid", 32'(out_valid), 32'd1);
         check("report_count", 32'(out_count), 32'(v.cnt));
         check("report_in_ready", 32'(in_ready), 32'd0);
         check("report_ser", {30'd0, ser_bit, ser_match}, 32'd0);
         if (h < hold) @(negedge clk);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check("back_idle", {30'd0, in_ready, out_valid}, 32'd2);
   endtask

   initial begin
      int   k;
      int   last_acc;
      int   exp_q [$];
      logic seen;

      tab[0] = '{16'hDDDD, 4'b1101,  4, 16'h8888};
      tab[1] = '{16'hFFFF, 4'b1111, 13, 16'hFFF8};
      tab[2] = '{16'h0000, 4'b1101,  0, 16'h0000};
      tab[3] = '{16'hD000, 4'b1101,  1, 16'h0008};
      tab[4] = '{16'h000D, 4'b1101,  1, 16'h8000};
      tab[5] = '{16'h8000, 4'b0001,  0, 16'h0000};
      tab[6] = '{16'hA5A5, 4'b0101,  2, 16'h8080};
      tab[7] = '{16'hAAAA, 4'b1010,  7, 16'hAAA8};

      reset     = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      pattern   = '0;
      out_ready = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_outputs", {26'd0, in_ready, out_valid, out_count}, {26'd0, 1'b1, 1'b0, 5'd0});
      check("rst_ser", {30'd0, ser_bit, ser_match}, 32'd0);
      reset = 1'b1;

      // Table sweep; 3 then 4 also shows no match carried across a word boundary.
      for (int i = 0; i < NVEC; i++) run_scan(tab[i], 0);

      // Consumer stalls for 10 cycles in REPORT.
      run_scan(tab[0], 10);

      // Reset asserted mid-scan, between clock edges.
      in_valid = 1'b1;
      in_data  = 16'hFFFF;
      pattern  = 4'b1111;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (8) @(negedge clk);
      check("pre_rst_count", 32'(out_count), 32'd5);
      #1 reset = 1'b0;
      #1;
      check("async_rst_out", {26'd0, in_ready, out_valid, out_count}, {26'd0, 1'b1, 1'b0, 5'd0});
      check("async_rst_ser", {30'd0, ser_bit, ser_match}, 32'd0);
      @(negedge clk);
      reset = 1'b1;
      seen  = 1'b0;
      out_ready = 1'b1;
      repeat (20) begin
         if (out_valid) seen = 1'b1;
         @(negedge clk);
      end
      out_ready = 1'b0;
      check("no_result_after_rst", 32'(seen), 32'd0);
      run_scan(tab[6], 0);

      // Back-to-back accepts with in_valid held high and junk driven mid-scan.
      k        = 0;
      last_acc = 0;
      in_valid  = 1'b1;
      out_ready = 1'b1;
      for (int c = 0; c < 70; c++) begin
         if (in_ready && k < 3) begin
            in_data = tab[k].data;
            pattern = tab[k].pat;
            if (k > 0) check("accept_spacing", 32'(cyc - last_acc), 32'd18);
            last_acc = cyc;
            exp_q.push_back(tab[k].cnt);
            k++;
         end else begin
            if (in_ready) in_valid = 1'b0;
            in_data = 16'($urandom);
            pattern = 4'($urandom);
         end
         if (out_valid) begin
            if (exp_q.size() == 0) check("unexpected_result", 32'd1, 32'd0);
            else check("b2b_count", 32'(out_count), 32'(exp_q.pop_front()));
         end
         @(negedge clk);
      end
      check("b2b_accepts", 32'(k), 32'd3);
      check("b2b_results_left", 32'(exp_q.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_pattern_scan_ctrl
